rv64g_l2_probe_unit: RTL and testbench
======================================

// Module: rv64g_l2_probe_unit
// PURPOSE
//  Probe issuer/collector sitting directly downstream of the L2 MSHR. On start it loads the
//  MSHR's pending-probe mask, issues one TileLink Probe per masked core on channel B, and
//  consumes ProbeAck/ProbeAckData on channel C. It returns per-core acks to the MSHR and
//  signals done when every probed core has answered.
// PARAMETERS
//  ADDR_W   64  block address width
//  CORES    4   number of L1 clients; CID_W = $clog2(CORES)
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       async active-low reset
//  start_i          in   1       begin probe round (sampled only in IDLE)
//  start_addr_i     in   ADDR_W  block address to probe
//  start_mask_i     in   CORES   cores to probe
//  start_cap_i      in   2       cap param: 0=toT 1=toB 2=toN
//  busy_o           out  1       state != IDLE
//  set_probes_o     out  1       to MSHR set_probes_i
//  probes_mask_o    out  CORES   to MSHR probes_mask_i (=start_mask_i)
//  probe_ack_o      out  1       to MSHR probe_ack_i
//  probe_ack_id_o   out  CID_W   to MSHR probe_ack_id_i (=c_core_i)
//  b_valid_o        out  1       B-channel valid
//  b_ready_i        in   1       B-channel ready
//  b_opcode_o       out  3       constant 3'd6 (Probe)
//  b_param_o        out  2       latched cap
//  b_address_o      out  ADDR_W  latched address
//  b_core_o         out  CID_W   target core
//  c_valid_i        in   1       C-channel valid
//  c_ready_o        out  1       C-channel ready
//  c_opcode_i       in   3       4=ProbeAck 5=ProbeAckData
//  c_core_i         in   CID_W   responding core
//  c_last_i         in   1       last beat of message
//  done_o           out  1       one-cycle pulse: round complete
//  dirty_o          out  1       any ProbeAckData in round; valid with done_o
//  err_o            out  1       one-cycle pulse: unexpected C message
// BEHAVIOUR
//  - Reset: state=IDLE; to_send, outstanding, dirty cleared. All outputs 0 (b_param/b_address 0).
//  - States: IDLE, SEND, WAIT, DONE.
//  - IDLE: set_probes_o = start_i (combinational, same cycle); next edge latches addr, cap,
//    to_send=outstanding=start_mask_i, dirty=0; state->SEND, or ->DONE if mask==0.
//  - SEND: b_valid_o=1; b_core_o = lowest set bit of to_send. On b_valid&b_ready that bit
//    clears; when to_send becomes 0, ->WAIT. b_core_o is held stable while valid and not ready.
//  - c_ready_o=1 in SEND and WAIT, 0 in IDLE/DONE. C fire = c_valid_i & c_ready_o.
//  - Ack = C fire & c_last_i & opcode in {4,5} & outstanding[c_core_i]: clear bit, probe_ack_o=1
//    same cycle (combinational). Opcode 5 sets dirty (any beat).
//  - Ack is allowed before that core's Probe clears to_send only if already sent; an ack whose
//    core is outstanding but still in to_send -> err_o, dropped.
//  - C fire & c_last_i with core not outstanding, or opcode not in {4,5} -> err_o pulse, no
//    state change. Non-last beats are consumed silently.
//  - Same-cycle B fire and ack: both take effect.
//  - SEND/WAIT -> DONE on the edge where to_send==0 and outstanding==0 (incl. after the final ack).
//  - DONE: done_o=1, dirty_o=dirty for one cycle; -> IDLE. start_i ignored outside IDLE.
//  - Latency: mask 0 -> done 1 cycle after start; single core, ready=1, ack next cycle ->
//    done 3 cycles after start.
//  - set_probes_o and probe_ack_o never coincide (different states).
//  - Async reset mid-round aborts with no done_o; MSHR is deallocated by the FSM separately.
// STRUCTURE
//  - rv64g_l2_pkg: TL opcodes (PROBE=6, PROBE_ACK=4, PROBE_ACK_DATA=5), cap encodings,
//    state enum.
//  - Sub-module rv64g_l2_prio_enc (CORES -> CID_W lowest-set-bit, plus any flag) for B target select.
// TESTING
//  1. start mask=4'b0000 -> set_probes_o pulse, done_o 1 cycle later, no b_valid, dirty_o=0.
//  2. mask=4'b1010, cap=2, b_ready=1 -> Probes to core 1 then 3 on consecutive cycles,
//     b_param=2; acks (op4) from 3 then 1 -> probe_ack_id 3,1; done_o after the second ack.
//  3. b_ready held 0 for 5 cycles with mask=4'b0100 -> b_valid held, b_core=2 stable, no done.
//  4. mask=4'b0001, ProbeAckData 4 beats (last on beat 4) -> single probe_ack_o on beat 4,
//     done_o with dirty_o=1.
//  5. ack from core 2 when mask=4'b0001 -> err_o pulse, outstanding unchanged, still busy.
//  6. rst_n low during WAIT -> outputs 0 async, IDLE; a new start works normally afterwards.

Source files
------------

// File: rtl/rv64g_l2_pkg.sv
// ----------------------------------------------------------------------------
// rv64g_l2_pkg
// Shared definitions for the L2 probe unit: TileLink B/C opcodes used by the
// probe flow, probe cap encodings and the probe FSM state type.
// ----------------------------------------------------------------------------
package rv64g_l2_pkg;

   localparam logic [2:0] TlProbe        = 3'd6;
   localparam logic [2:0] TlProbeAck     = 3'd4;
   localparam logic [2:0] TlProbeAckData = 3'd5;

   localparam logic [1:0] CapToT = 2'd0;
   localparam logic [1:0] CapToB = 2'd1;
   localparam logic [1:0] CapToN = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWait,
      StDone
   } probe_state_e;

   function automatic logic is_probe_ack(input logic [2:0] opcode);
      return (opcode == TlProbeAck) || (opcode == TlProbeAckData);
   endfunction

endpackage

// File: rtl/rv64g_l2_probe_unit_if.sv
// ----------------------------------------------------------------------------
// rv64g_l2_probe_unit_if
// TileLink channel B (Probe, unit -> L1) and channel C (ProbeAck[Data],
// L1 -> unit) signals of the L2 probe unit.
//   master : the probe unit (drives B payload/valid and C ready)
//   slave  : the L1 side (drives B ready and C payload/valid)
// ----------------------------------------------------------------------------
interface rv64g_l2_probe_unit_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned CORES  = 4,
   localparam int unsigned CID_W = (CORES > 1) ? $clog2(CORES) : 1
);

   logic              b_valid;
   logic              b_ready;
   logic [2:0]        b_opcode;
   logic [1:0]        b_param;
   logic [ADDR_W-1:0] b_address;
   logic [CID_W-1:0]  b_core;

   logic              c_valid;
   logic              c_ready;
   logic [2:0]        c_opcode;
   logic [CID_W-1:0]  c_core;
   logic              c_last;

   modport master (
      output b_valid, b_opcode, b_param, b_address, b_core,
      input  b_ready,
      input  c_valid, c_opcode, c_core, c_last,
      output c_ready
   );

   modport slave (
      input  b_valid, b_opcode, b_param, b_address, b_core,
      output b_ready,
      output c_valid, c_opcode, c_core, c_last,
      input  c_ready
   );

endinterface

// File: rtl/rv64g_l2_prio_enc.sv
// ----------------------------------------------------------------------------
// rv64g_l2_prio_enc
// Lowest-set-bit priority encoder.
//   req_i : request vector
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : at least one bit set
// ----------------------------------------------------------------------------
module rv64g_l2_prio_enc #(
   parameter int unsigned N = 4,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = W'(i);
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/rv64g_l2_probe_unit.sv
// ----------------------------------------------------------------------------
// rv64g_l2_probe_unit
// Probe issuer/collector downstream of the L2 MSHR. On start it latches the
// pending-probe mask, issues one Probe per masked core on channel B (lowest
// core first), collects ProbeAck/ProbeAckData on channel C, reports per-core
// acks to the MSHR and pulses done_o once every probed core has answered.
//   clk, rst_n          clock, asynchronous active-low reset
//   start_*_i           round request (sampled only while idle)
//   busy_o              round in progress
//   set_probes_o,
//   probes_mask_o       MSHR probe-mask load, same cycle as start_i
//   probe_ack_o,
//   probe_ack_id_o      per-core ack to the MSHR
//   tl_io               TileLink B/C channels (master side)
//   done_o, dirty_o     round-complete pulse; dirty_o = any ProbeAckData seen
//   err_o               unexpected C message pulse
// ----------------------------------------------------------------------------
module rv64g_l2_probe_unit
   import rv64g_l2_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned CORES  = 4,
   localparam int unsigned CID_W = (CORES > 1) ? $clog2(CORES) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [ADDR_W-1:0]         start_addr_i,
   input  logic [CORES-1:0]          start_mask_i,
   input  logic [1:0]                start_cap_i,
   output logic                      busy_o,
   output logic                      set_probes_o,
   output logic [CORES-1:0]          probes_mask_o,
   output logic                      probe_ack_o,
   output logic [CID_W-1:0]          probe_ack_id_o,
   rv64g_l2_probe_unit_if.master     tl_io,
   output logic                      done_o,
   output logic                      dirty_o,
   output logic                      err_o
);

   probe_state_e      state_q, state_d;
   logic [CORES-1:0]  to_send_q, to_send_d;
   logic [CORES-1:0]  outstanding_q, outstanding_d;
   logic              dirty_q, dirty_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        cap_q, cap_d;

   logic [CID_W-1:0]  tgt_core;
   logic              tgt_any;
   logic [CORES-1:0]  b_onehot, c_onehot;
   logic              in_round, b_valid, b_fire, c_fire, c_end, ack_ok;

   rv64g_l2_prio_enc #(
      .N (CORES),
      .W (CID_W)
   ) u_prio_enc (
      .req_i (to_send_q),
      .idx_o (tgt_core),
      .any_o (tgt_any)
   );

   assign in_round = (state_q == StSend) || (state_q == StWait);
   assign b_valid  = (state_q == StSend) && tgt_any;
   assign b_fire   = b_valid && tl_io.b_ready;
   assign b_onehot = CORES'(1) << tgt_core;
   assign c_onehot = CORES'(1) << tl_io.c_core;
   assign c_fire   = tl_io.c_valid && in_round;
   assign c_end    = c_fire && tl_io.c_last;

   // An ack is accepted only from a core that was probed and has not yet
   // answered; a core still waiting for its Probe cannot legally respond.
   assign ack_ok = c_end && is_probe_ack(tl_io.c_opcode)
                   && |(outstanding_q & c_onehot)
                   && !(|(to_send_q & c_onehot));

   always_comb begin
      state_d       = state_q;
      to_send_d     = to_send_q;
      outstanding_d = outstanding_q;
      dirty_d       = dirty_q;
      addr_d        = addr_q;
      cap_d         = cap_q;
      set_probes_o  = 1'b0;
      probes_mask_o = '0;
      done_o        = 1'b0;
      dirty_o       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               set_probes_o  = 1'b1;
               probes_mask_o = start_mask_i;
               addr_d        = start_addr_i;
               cap_d         = start_cap_i;
               to_send_d     = start_mask_i;
               outstanding_d = start_mask_i;
               dirty_d       = 1'b0;
               state_d       = (start_mask_i == '0) ? StDone : StSend;
            end
         end
         StSend, StWait: begin
            if (b_fire) to_send_d = to_send_q & ~b_onehot;
            if (ack_ok) outstanding_d = outstanding_q & ~c_onehot;
            if (c_fire && (tl_io.c_opcode == TlProbeAckData)) dirty_d = 1'b1;
            if (to_send_d == '0) begin
               state_d = (outstanding_d == '0) ? StDone : StWait;
            end else begin
               state_d = StSend;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            dirty_o = dirty_q;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         to_send_q     <= '0;
         outstanding_q <= '0;
         dirty_q       <= 1'b0;
         addr_q        <= '0;
         cap_q         <= '0;
      end else begin
         state_q       <= state_d;
         to_send_q     <= to_send_d;
         outstanding_q <= outstanding_d;
         dirty_q       <= dirty_d;
         addr_q        <= addr_d;
         cap_q         <= cap_d;
      end
   end

   assign busy_o          = (state_q != StIdle);
   assign probe_ack_o     = ack_ok;
   assign probe_ack_id_o  = ack_ok ? tl_io.c_core : '0;
   assign err_o           = c_end && !ack_ok;

   assign tl_io.b_valid   = b_valid;
   assign tl_io.b_opcode  = b_valid ? TlProbe : 3'd0;
   assign tl_io.b_param   = cap_q;
   assign tl_io.b_address = addr_q;
   assign tl_io.b_core    = tgt_core;
   assign tl_io.c_ready   = in_round;

endmodule

// File: tb/tb_rv64g_l2_probe_unit.sv
// ----------------------------------------------------------------------------
// tb_rv64g_l2_probe_unit
// Self-checking bench: table of full probe rounds plus directed sequences for
// B back-pressure, multi-beat ProbeAckData, unexpected acks and async reset.
// ----------------------------------------------------------------------------
module tb_rv64g_l2_probe_unit;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [63:0] start_addr_i;
   logic [3:0]  start_mask_i;
   logic [1:0]  start_cap_i;
   logic        busy_o, set_probes_o, probe_ack_o, done_o, dirty_o, err_o;
   logic [3:0]  probes_mask_o;
   logic [1:0]  probe_ack_id_o;

   int checks = 0;
   int errors = 0;

   rv64g_l2_probe_unit_if #(.ADDR_W(64), .CORES(4)) tl ();

   rv64g_l2_probe_unit #(.ADDR_W(64), .CORES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .start_addr_i   (start_addr_i),
      .start_mask_i   (start_mask_i),
      .start_cap_i    (start_cap_i),
      .busy_o         (busy_o),
      .set_probes_o   (set_probes_o),
      .probes_mask_o  (probes_mask_o),
      .probe_ack_o    (probe_ack_o),
      .probe_ack_id_o (probe_ack_id_o),
      .tl_io          (tl),
      .done_o         (done_o),
      .dirty_o        (dirty_o),
      .err_o          (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [3:0]       mask;
      logic [1:0]       cap;
      logic [63:0]      addr;
      int               n;
      logic [3:0][1:0]  order;     // expected Probe targets, order[0] first
      logic             ack_rev;   // ack in reverse probe order
      logic [3:0]       data_mask; // cores answering with ProbeAckData
      logic             exp_dirty;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic slot();
      @(negedge clk);
   endtask

   task automatic c_drive(input logic v, input logic [1:0] core, input logic [2:0] op,
                          input logic last);
      tl.c_valid  = v;
      tl.c_core   = core;
      tl.c_opcode = op;
      tl.c_last   = last;
   endtask

   task automatic do_start(input logic [3:0] mask, input logic [1:0] cap,
                           input logic [63:0] addr);
      slot();
      start_i      = 1'b1;
      start_mask_i = mask;
      start_cap_i  = cap;
      start_addr_i = addr;
      #1;
      chk("set_probes", set_probes_o, 1);
      chk("probes_mask", probes_mask_o, mask);
   endtask

   task automatic wait_done(input logic exp_dirty);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         slot();
         start_i    = 1'b0;
         tl.b_ready = 1'b0;
         c_drive(1'b0, 2'd0, 3'd0, 1'b0);
         #1;
         if (done_o) got = 1'b1;
      end
      chk("done_seen", got, 1);
      if (got) begin
         chk("dirty", dirty_o, exp_dirty);
         chk("done_no_bvalid", tl.b_valid, 0);
      end
      slot();
      #1;
      chk("done_pulse_end", done_o, 0);
      chk("idle_after_done", busy_o, 0);
   endtask

   task automatic run_round(input vec_t v);
      logic [1:0] core;
      do_start(v.mask, v.cap, v.addr);
      for (int k = 0; k < v.n; k++) begin
         slot();
         start_i    = 1'b0;
         tl.b_ready = 1'b1;
         #1;
         chk("b_valid", tl.b_valid, 1);
         chk("b_core", tl.b_core, v.order[k]);
         chk("b_param", tl.b_param, v.cap);
         chk("b_address", tl.b_address, v.addr);
         chk("b_opcode", tl.b_opcode, 6);
      end
      for (int k = 0; k < v.n; k++) begin
         core = v.ack_rev ? v.order[v.n-1-k] : v.order[k];
         slot();
         start_i    = 1'b0;
         tl.b_ready = 1'b0;
         c_drive(1'b1, core, v.data_mask[core] ? 3'd5 : 3'd4, 1'b1);
         #1;
         chk("probe_ack", probe_ack_o, 1);
         chk("probe_ack_id", probe_ack_id_o, core);
         chk("no_err", err_o, 0);
      end
      wait_done(v.exp_dirty);
   endtask

   initial begin
      vecs[0] = '{mask: 4'b0000, cap: 2'd0, addr: 64'h0, n: 0, order: '0,
                  ack_rev: 1'b0, data_mask: 4'b0000, exp_dirty: 1'b0};
      vecs[1] = '{mask: 4'b1010, cap: 2'd2, addr: 64'h0000_0000_8000_1040, n: 2,
                  order: {2'd0, 2'd0, 2'd3, 2'd1}, ack_rev: 1'b1, data_mask: 4'b0000,
                  exp_dirty: 1'b0};
      vecs[2] = '{mask: 4'b1111, cap: 2'd1, addr: 64'hFFFF_FFFF_FFFF_FFC0, n: 4,
                  order: {2'd3, 2'd2, 2'd1, 2'd0}, ack_rev: 1'b0, data_mask: 4'b0100,
                  exp_dirty: 1'b1};
      vecs[3] = '{mask: 4'b0001, cap: 2'd0, addr: 64'h40, n: 1, order: '0,
                  ack_rev: 1'b0, data_mask: 4'b0000, exp_dirty: 1'b0};
      vecs[4] = '{mask: 4'b1000, cap: 2'd1, addr: 64'h1234_5678_9ABC_DE00, n: 1,
                  order: {2'd0, 2'd0, 2'd0, 2'd3}, ack_rev: 1'b0, data_mask: 4'b1000,
                  exp_dirty: 1'b1};

      rst_n        = 1'b0;
      start_i      = 1'b0;
      start_addr_i = '0;
      start_mask_i = '0;
      start_cap_i  = '0;
      tl.b_ready   = 1'b0;
      c_drive(1'b0, 2'd0, 3'd0, 1'b0);
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_b_valid", tl.b_valid, 0);
      chk("rst_c_ready", tl.c_ready, 0);
      chk("rst_b_param", tl.b_param, 0);
      chk("rst_b_address", tl.b_address, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_set_probes", set_probes_o, 0);
      slot();
      rst_n = 1'b1;

      // Table of complete rounds.
      for (int i = 0; i < 5; i++) run_round(vecs[i]);

      // B back-pressure: Probe held with a stable target; start ignored while busy.
      do_start(4'b0100, 2'd1, 64'hA0);
      for (int i = 0; i < 5; i++) begin
         slot();
         start_i      = 1'b1;
         start_mask_i = 4'b1111;
         tl.b_ready   = 1'b0;
         #1;
         chk("stall_b_valid", tl.b_valid, 1);
         chk("stall_b_core", tl.b_core, 2);
         chk("stall_no_done", done_o, 0);
         chk("stall_no_set_probes", set_probes_o, 0);
      end
      slot();
      start_i    = 1'b0;
      tl.b_ready = 1'b1;
      #1;
      chk("stall_release_core", tl.b_core, 2);
      slot();
      tl.b_ready = 1'b0;
      c_drive(1'b1, 2'd2, 3'd4, 1'b1);
      #1;
      chk("stall_ack", probe_ack_o, 1);
      chk("stall_ack_id", probe_ack_id_o, 2);
      wait_done(1'b0);

      // Multi-beat ProbeAckData: only the last beat acks.
      do_start(4'b0001, 2'd2, 64'hB00);
      slot();
      start_i    = 1'b0;
      tl.b_ready = 1'b1;
      #1;
      chk("mb_b_core", tl.b_core, 0);
      for (int beat = 1; beat <= 4; beat++) begin
         slot();
         tl.b_ready = 1'b0;
         c_drive(1'b1, 2'd0, 3'd5, beat == 4);
         #1;
         chk("mb_probe_ack", probe_ack_o, (beat == 4) ? 1 : 0);
         chk("mb_no_err", err_o, 0);
      end
      wait_done(1'b1);

      // Unexpected acks: unsent core, unprobed core, bad opcode.
      do_start(4'b0011, 2'd0, 64'hC00);
      slot();
      start_i = 1'b0;
      c_drive(1'b1, 2'd0, 3'd4, 1'b1);
      #1;
      chk("err_unsent", err_o, 1);
      chk("err_unsent_noack", probe_ack_o, 0);
      slot();
      c_drive(1'b1, 2'd2, 3'd4, 1'b1);
      #1;
      chk("err_unprobed_send", err_o, 1);
      slot();
      c_drive(1'b0, 2'd0, 3'd0, 1'b0);
      tl.b_ready = 1'b1;
      #1;
      chk("err_err_clear", err_o, 0);
      chk("err_b_core0", tl.b_core, 0);
      slot();
      #1;
      chk("err_b_core1", tl.b_core, 1);
      slot();
      tl.b_ready = 1'b0;
      c_drive(1'b1, 2'd2, 3'd4, 1'b1);
      #1;
      chk("err_unprobed_wait", err_o, 1);
      chk("err_unprobed_noack", probe_ack_o, 0);
      slot();
      c_drive(1'b1, 2'd0, 3'd3, 1'b1);
      #1;
      chk("err_bad_opcode", err_o, 1);
      slot();
      c_drive(1'b1, 2'd0, 3'd4, 1'b1);
      #1;
      chk("err_good_ack0", probe_ack_o, 1);
      chk("err_good_id0", probe_ack_id_o, 0);
      slot();
      c_drive(1'b0, 2'd0, 3'd0, 1'b0);
      #1;
      chk("err_still_busy", busy_o, 1);
      chk("err_no_done", done_o, 0);
      slot();
      c_drive(1'b1, 2'd0, 3'd4, 1'b1);
      #1;
      chk("err_dup_ack", err_o, 1);
      slot();
      c_drive(1'b1, 2'd1, 3'd4, 1'b1);
      #1;
      chk("err_good_ack1", probe_ack_o, 1);
      chk("err_good_id1", probe_ack_id_o, 1);
      wait_done(1'b0);

      // Async reset in WAIT aborts the round without done_o.
      do_start(4'b0001, 2'd1, 64'hD00);
      slot();
      start_i    = 1'b0;
      tl.b_ready = 1'b1;
      slot();
      tl.b_ready = 1'b0;
      #1;
      chk("rw_busy", busy_o, 1);
      chk("rw_c_ready", tl.c_ready, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rw_rst_busy", busy_o, 0);
      chk("rw_rst_c_ready", tl.c_ready, 0);
      chk("rw_rst_b_address", tl.b_address, 0);
      chk("rw_rst_b_param", tl.b_param, 0);
      chk("rw_rst_done", done_o, 0);
      slot();
      rst_n = 1'b1;
      #1;
      chk("rw_post_done", done_o, 0);
      run_round(vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
